// File: rtl/spi_receiver_pkg.sv
// rtl/spi_receiver_pkg.sv - shared frame constants and FSM state type for the SD SPI command receiver
package spi_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_CMD  = 3'd2,
        ST_ARG  = 3'd3,
        ST_CRC  = 3'd4,
        ST_END  = 3'd5
    } state_e;

    localparam int   CMD_W     = 6;
    localparam int   ARG_W     = 32;
    localparam int   CRC_W     = 7;
    localparam logic START_BIT = 1'b0;
    localparam logic TX_BIT    = 1'b1;
    localparam logic END_BIT   = 1'b1;

endpackage

// File: rtl/spi_receiver_edge_sampler.sv
// rtl/spi_receiver_edge_sampler.sv - oversampled SPI_CLK rising-edge detector producing a one-cycle sample strobe
module spi_receiver_edge_sampler (
    input  logic clock,
    input  logic reset,
    input  logic spi_clk,
    input  logic spi_cs,
    output logic sample
);

    logic clk_q, clk_d;
    logic armed_q, armed_d;

    // armed_q stays low until SPI_CLK has been seen low, so a clock held high
    // across reset release cannot masquerade as a rising edge.
    always_comb begin
        clk_d   = spi_clk;
        armed_d = armed_q | ~spi_clk;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            clk_q   <= clk_d;
            armed_q <= armed_d;
        end
    end

    assign sample = spi_clk & ~clk_q & armed_q & ~spi_cs;

endmodule

// File: rtl/spi_receiver.sv
// rtl/spi_receiver.sv - SD-card SPI-mode 48-bit command frame deframer (slave side)
module spi_receiver
    import spi_receiver_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        io_SPI_CLK,
    input  logic        io_SPI_CS,
    input  logic        io_SPI_DI,
    output logic        io_SPI_DO,
    input  logic        io_DO,
    output logic        io_DI,
    output logic        io_CommandReadFinished,
    output logic        io_ArgumentReadFinished,
    output logic        io_ReadSuccess,
    output logic [5:0]  io_Command,
    output logic [31:0] io_CommandArgument,
    output logic [2:0]  io____state,
    output logic [2:0]  io____counter,
    output logic [7:0]  io____buffer
);

    logic        sample;
    state_e      state_q, state_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  buffer_q, buffer_d;
    logic [5:0]  command_q, command_d;
    logic [31:0] argument_q, argument_d;
    logic        cmd_done_q, cmd_done_d;
    logic        arg_done_q, arg_done_d;
    logic        success_q, success_d;

    spi_receiver_edge_sampler u_edge (
        .clock   (clock),
        .reset   (reset),
        .spi_clk (io_SPI_CLK),
        .spi_cs  (io_SPI_CS),
        .sample  (sample)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            buffer_q   <= 8'hFF;
            command_q  <= '0;
            argument_q <= '0;
            cmd_done_q <= 1'b0;
            arg_done_q <= 1'b0;
            success_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            buffer_q   <= buffer_d;
            command_q  <= command_d;
            argument_q <= argument_d;
            cmd_done_q <= cmd_done_d;
            arg_done_q <= arg_done_d;
            success_q  <= success_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        buffer_d   = buffer_q;
        command_d  = command_q;
        argument_d = argument_q;
        cmd_done_d = cmd_done_q;
        arg_done_d = arg_done_q;
        success_d  = success_q;
        // Deselect abandons frame progress but leaves the last results readable.
        if (io_SPI_CS) begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
        end else if (sample) begin
            buffer_d = {buffer_q[6:0], io_SPI_DI};
            case (state_q)
                ST_IDLE: begin
                    if (io_SPI_DI == START_BIT) begin
                        state_d    = ST_TX;
                        bitcnt_d   = '0;
                        cmd_done_d = 1'b0;
                        arg_done_d = 1'b0;
                        success_d  = 1'b0;
                        command_d  = '0;
                        argument_d = '0;
                    end
                end
                ST_TX: begin
                    bitcnt_d = '0;
                    state_d  = (io_SPI_DI == TX_BIT) ? ST_CMD : ST_IDLE;
                end
                ST_CMD: begin
                    command_d[bitcnt_q[2:0]] = io_SPI_DI;
                    if (bitcnt_q == 6'(CMD_W - 1)) begin
                        cmd_done_d = 1'b1;
                        state_d    = ST_ARG;
                        bitcnt_d   = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + 6'd1;
                    end
                end
                ST_ARG: begin
                    argument_d[bitcnt_q[4:0]] = io_SPI_DI;
                    if (bitcnt_q == 6'(ARG_W - 1)) begin
                        arg_done_d = 1'b1;
                        state_d    = ST_CRC;
                        bitcnt_d   = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + 6'd1;
                    end
                end
                ST_CRC: begin
                    if (bitcnt_q == 6'(CRC_W - 1)) begin
                        state_d  = ST_END;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + 6'd1;
                    end
                end
                ST_END: begin
                    if (io_SPI_DI == END_BIT) success_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d  = ST_IDLE;
                    bitcnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        io_SPI_DO               = io_SPI_CS ? 1'b1 : io_DO;
        io_DI                   = io_SPI_DI;
        io_CommandReadFinished  = cmd_done_q;
        io_ArgumentReadFinished = arg_done_q;
        io_ReadSuccess          = success_q;
        io_Command              = command_q;
        io_CommandArgument      = argument_q;
        io____state             = state_q;
        io____counter           = bitcnt_q[2:0];
        io____buffer            = buffer_q;
    end

endmodule

// File: tb/tb_spi_receiver.sv
// tb/tb_spi_receiver.sv - self-checking bench for spi_receiver: frame table, hand sequences, random frames with aborts
module tb_spi_receiver;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_SPI_CLK, io_SPI_CS, io_SPI_DI, io_DO;
    logic        io_SPI_DO, io_DI;
    logic        io_CommandReadFinished, io_ArgumentReadFinished, io_ReadSuccess;
    logic [5:0]  io_Command;
    logic [31:0] io_CommandArgument;
    logic [2:0]  io____state, io____counter;
    logic [7:0]  io____buffer;

    int vectors = 0;
    int errors  = 0;
    logic [7:0] hist;

    typedef struct {
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic        endb;
        logic        exp_success;
        logic [7:0]  exp_buffer;
    } vec_t;
    vec_t vecs[5];

    always #5 clock = ~clock;

    spi_receiver dut (
        .clock                   (clock),
        .reset                   (reset),
        .io_SPI_CLK              (io_SPI_CLK),
        .io_SPI_CS               (io_SPI_CS),
        .io_SPI_DI               (io_SPI_DI),
        .io_SPI_DO               (io_SPI_DO),
        .io_DO                   (io_DO),
        .io_DI                   (io_DI),
        .io_CommandReadFinished  (io_CommandReadFinished),
        .io_ArgumentReadFinished (io_ArgumentReadFinished),
        .io_ReadSuccess          (io_ReadSuccess),
        .io_Command              (io_Command),
        .io_CommandArgument      (io_CommandArgument),
        .io____state             (io____state),
        .io____counter           (io____counter),
        .io____buffer            (io____buffer)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One SPI bit: low phase, then rising edge; settles by the final negedge.
    task automatic spi_bit(input logic b);
        @(negedge clock);
        io_SPI_DI  = b;
        io_SPI_CLK = 1'b0;
        repeat (2) @(negedge clock);
        io_SPI_CLK = 1'b1;
        if (!io_SPI_CS) hist = {hist[6:0], b};
        repeat (3) @(negedge clock);
    endtask

    function automatic logic [47:0] mk_frame(input logic [5:0] c, input logic [31:0] a,
                                             input logic [6:0] crc, input logic e);
        logic [47:0] f;
        f[0] = 1'b0;
        f[1] = 1'b1;
        for (int i = 0; i < 6; i++)  f[2 + i] = c[i];
        for (int i = 0; i < 32; i++) f[8 + i] = a[i];
        for (int i = 0; i < 7; i++)  f[40 + i] = crc[6 - i];
        f[47] = e;
        return f;
    endfunction

    task automatic send_range(input logic [47:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) spi_bit(f[i]);
    endtask

    initial begin
        logic [47:0] f;
        logic [7:0]  bsave;
        vecs[0] = '{6'd59, 32'd128912,    7'b0000001, 1'b1, 1'b1, 8'b0000_0011};
        vecs[1] = '{6'd59, 32'd128912,    7'b0000001, 1'b0, 1'b0, 8'b0000_0010};
        vecs[2] = '{6'd0,  32'd0,         7'h00,      1'b1, 1'b1, 8'h01};
        vecs[3] = '{6'd63, 32'hFFFF_FFFF, 7'h7F,      1'b1, 1'b1, 8'hFF};
        vecs[4] = '{6'd17, 32'hDEAD_BEEF, 7'h55,      1'b0, 1'b0, 8'hAA};

        reset = 1'b0; io_SPI_CS = 1'b0; io_SPI_DI = 1'b0; io_DO = 1'b0; io_SPI_CLK = 1'b0;
        hist = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            io_SPI_CLK = ~io_SPI_CLK;
            io_SPI_DI  = 1'($urandom);
        end
        io_SPI_CLK = 1'b1;
        io_SPI_DI  = 1'b0;
        @(negedge clock);
        chk("rst_state", 32'(io____state), 0);
        chk("rst_buffer", 32'(io____buffer), 32'hFF);
        chk("rst_counter", 32'(io____counter), 0);
        chk("rst_flags", {io_CommandReadFinished, io_ArgumentReadFinished, io_ReadSuccess}, 0);
        chk("rst_cmd", 32'(io_Command), 0);
        chk("rst_arg", io_CommandArgument, 0);
        chk("rst_do", 32'(io_SPI_DO), 0);

        // SPI_CLK already high when reset lifts must not be taken as a sample
        reset = 1'b1;
        repeat (4) @(negedge clock);
        chk("clk_high_release_state", 32'(io____state), 0);
        chk("clk_high_release_buf", 32'(io____buffer), 32'hFF);

        for (int i = 0; i < 8; i++) spi_bit(1'b1);
        chk("idle_ones_state", 32'(io____state), 0);
        chk("idle_ones_flags", {io_CommandReadFinished, io_ArgumentReadFinished, io_ReadSuccess}, 0);
        chk("idle_ones_buffer", 32'(io____buffer), 32'hFF);

        f = mk_frame(6'd59, 32'd128912, 7'b0000001, 1'b1);
        send_range(f, 0, 7);
        chk("cmd_state", 32'(io____state), 3);
        chk("cmd_done", 32'(io_CommandReadFinished), 1);
        chk("cmd_value", 32'(io_Command), 59);
        chk("cmd_argdone", 32'(io_ArgumentReadFinished), 0);
        send_range(f, 8, 39);
        chk("arg_state", 32'(io____state), 4);
        chk("arg_done", 32'(io_ArgumentReadFinished), 1);
        chk("arg_value", io_CommandArgument, 128912);
        send_range(f, 40, 47);
        chk("end_state", 32'(io____state), 0);
        chk("end_success", 32'(io_ReadSuccess), 1);
        chk("end_buffer", 32'(io____buffer), 32'h03);

        for (int v = 0; v < 5; v++) begin
            send_range(mk_frame(vecs[v].cmd, vecs[v].arg, vecs[v].crc, vecs[v].endb), 0, 47);
            chk($sformatf("tbl%0d_state", v), 32'(io____state), 0);
            chk($sformatf("tbl%0d_success", v), 32'(io_ReadSuccess), 32'(vecs[v].exp_success));
            chk($sformatf("tbl%0d_cmd", v), 32'(io_Command), 32'(vecs[v].cmd));
            chk($sformatf("tbl%0d_arg", v), io_CommandArgument, vecs[v].arg);
            chk($sformatf("tbl%0d_flags", v), {io_CommandReadFinished, io_ArgumentReadFinished}, 3);
            chk($sformatf("tbl%0d_buffer", v), 32'(io____buffer), 32'(vecs[v].exp_buffer));
        end

        // Abort in ARG, CS-high clock ignored, then start bit and TX framing error
        send_range(f, 0, 19);
        chk("abort_pre_counter", 32'(io____counter), 4);
        chk("abort_pre_state", 32'(io____state), 3);
        @(negedge clock);
        io_SPI_CS = 1'b1;
        @(negedge clock);
        chk("abort_state", 32'(io____state), 0);
        chk("abort_do", 32'(io_SPI_DO), 1);
        chk("abort_success", 32'(io_ReadSuccess), 0);
        chk("abort_keep_cmd", {26'd0, io_Command}, 59);
        chk("abort_keep_cmddone", 32'(io_CommandReadFinished), 1);
        bsave = hist;
        spi_bit(1'b0);
        chk("cs_high_nosample_state", 32'(io____state), 0);
        chk("cs_high_nosample_buf", 32'(io____buffer), 32'(bsave));
        io_SPI_CS = 1'b0;
        spi_bit(1'b0);
        chk("start_state", 32'(io____state), 1);
        chk("start_clears_flag", 32'(io_CommandReadFinished), 0);
        chk("start_clears_cmd", 32'(io_Command), 0);
        spi_bit(1'b0);
        chk("txerr_state", 32'(io____state), 0);
        chk("txerr_cmddone", 32'(io_CommandReadFinished), 0);
        chk("txerr_do", 32'(io_SPI_DO), 32'(io_DO));

        // Random frames, some aborted by CS after k bits
        for (int it = 0; it < 25; it++) begin
            logic [5:0]  rc;
            logic [31:0] ra;
            logic [6:0]  rcrc;
            logic        re;
            int          k, nc, na;
            longint      ecmd, earg;
            rc = 6'($urandom); ra = $urandom; rcrc = 7'($urandom); re = 1'($urandom);
            io_DO = 1'($urandom);
            k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 47)) : 48;
            send_range(mk_frame(rc, ra, rcrc, re), 0, k - 1);
            if (k < 48) begin
                @(negedge clock);
                io_SPI_CS = 1'b1;
                repeat (2) @(negedge clock);
                chk("rnd_abort_do", 32'(io_SPI_DO), 1);
                io_SPI_CS = 1'b0;
                @(negedge clock);
            end
            nc = (k - 2 > 6) ? 6 : k - 2;
            na = (k - 8 < 0) ? 0 : ((k - 8 > 32) ? 32 : k - 8);
            ecmd = longint'(rc) & ((64'd1 << nc) - 1);
            earg = longint'(ra) & ((64'd1 << na) - 1);
            chk("rnd_state", 32'(io____state), 0);
            chk("rnd_counter", 32'(io____counter), 0);
            chk("rnd_cmd", 32'(io_Command), 32'(ecmd));
            chk("rnd_arg", io_CommandArgument, 32'(earg));
            chk("rnd_cmddone", 32'(io_CommandReadFinished), 32'(k >= 8));
            chk("rnd_argdone", 32'(io_ArgumentReadFinished), 32'(k >= 40));
            chk("rnd_success", 32'(io_ReadSuccess), 32'(k == 48 && re));
            chk("rnd_buffer", 32'(io____buffer), 32'(hist));
            chk("rnd_di", 32'(io_DI), 32'(io_SPI_DI));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
